gb_fb_writer: RTL
=================

GB_FB_WRITER -- requirements
Module: gb_fb_writer

Interface
REQ-001 SHALL have parameter GB_W, default 160, active pixels per Game Boy line.
REQ-002 SHALL have parameter GB_H, default 144, active lines per Game Boy frame.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge; one clock only.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port gb_pix  input  2  Game Boy LCD pixel shade, sampled when gb_valid=1.
REQ-006 SHALL have port gb_valid  input  1  pixel strobe, one pixel per cycle high.
REQ-007 SHALL have port gb_hs  input  1  LCD line sync, clk-synchronous; rising edge = end of line.
REQ-008 SHALL have port gb_vs  input  1  LCD frame sync, clk-synchronous; rising edge = start of frame.
REQ-009 SHALL have port wr_en  output  1  framebuffer write strobe.
REQ-010 SHALL have port wr_addr  output  15  framebuffer address, y*GB_W+x.
REQ-011 SHALL have port wr_data  output  2  framebuffer write data.
REQ-012 SHALL have port vsi  output  1  one-cycle frame-start pulse for the VGA timing generator.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when line GB_H-1 completes.
REQ-014 SHALL have port err_long  output  1  sticky: pixel dropped (x or y out of range).
REQ-015 SHALL have port err_short  output  1  sticky: line ended with 0<x<GB_W.

Function
REQ-016 SHALL detect edges by one register stage each on gb_hs and gb_vs; an edge acts in the cycle it is seen (prev=0, cur=1).
REQ-017 SHALL implement states WAIT_VS, CAPTURE, DONE; WAIT_VS->CAPTURE on gb_vs edge; CAPTURE->DONE on hs edge completing line GB_H-1; DONE->CAPTURE on gb_vs edge.
REQ-018 SHALL, on any gb_vs edge in any state: x=0, y=0, line_base=0, state CAPTURE, vsi=1 next cycle.
REQ-019 SHALL ignore gb_valid and gb_hs in WAIT_VS; no writes before the first gb_vs edge.
REQ-020 SHALL, in CAPTURE with gb_valid=1, x<GB_W and y<GB_H: register wr_en=1, wr_addr=line_base+x, wr_data=gb_pix on the next clock, then x<=x+1; latency exactly 1 cycle.
REQ-021 SHALL compute line_base incrementally (+GB_W per line); no multiplier.
REQ-022 SHALL drive wr_en=0 in every cycle without an accepted pixel; wr_addr/wr_data hold their last value.
REQ-023 SHALL, on gb_valid with x=GB_W or y>=GB_H or state DONE, drop the pixel (wr_en=0) and set err_long.
REQ-024 SHALL, on gb_hs edge in CAPTURE: x<=0, y<=y+1, line_base<=line_base+GB_W; set err_short if 0<x<GB_W; hs edge with x=0 counts as an empty line.
REQ-025 SHALL, when the hs edge advances y from GB_H-1, pulse frame_done for one cycle and enter DONE.
REQ-026 SHALL, with gb_valid and gb_hs edge in the same cycle, write the pixel to the current line first, then advance the line.
REQ-027 SHALL give the gb_vs edge priority over a simultaneous gb_hs edge (hs ignored) and over a simultaneous gb_valid (pixel not written).
REQ-028 SHALL keep vsi and frame_done each exactly one cycle wide.

Reset
REQ-029 SHALL, while rst=1, force state WAIT_VS, x=y=line_base=0, edge registers=0, wr_en=0, wr_addr=0, wr_data=0, vsi=0, frame_done=0, err_long=0, err_short=0.
REQ-030 SHALL, on rst mid-frame, abandon the frame; after release no writes occur until the next gb_vs edge.
REQ-031 SHALL clear err_long/err_short only by reset.

Verification
REQ-032 SHALL cover full frame: vs edge, 144 lines of 160 valid pixels each followed by hs edge -> 23040 writes, addresses 0..23039 in order, vsi one pulse, frame_done one pulse after last hs, no errors.
REQ-033 SHALL cover long line: 165 pixels on line 0 -> writes at 0..159 only, err_long=1, line 1 starts at addr 160.
REQ-034 SHALL cover short line: 100 pixels then hs on line 2 -> err_short=1, next pixel written at addr 480.
REQ-035 SHALL cover simultaneous events: valid+hs edge at x=159 -> addr 159 written, next pixel at 160; vs+valid same cycle -> no write, vsi pulse, next pixel at addr 0.
REQ-036 SHALL cover pre-sync and mid-frame reset: pixels before first vs -> wr_en stays 0; rst at line 50 -> all outputs 0, pixels ignored until vs, then first write at addr 0.
REQ-037 SHALL cover DONE: pixels after frame_done -> dropped, err_long=1; following vs edge -> capture resumes at addr 0.

Source files
------------

// File: rtl/gb_fb_writer.sv
// Game Boy LCD stream to linear framebuffer writer.
// Frames are aligned on the gb_vs edge; pixels go to y*GB_W+x with one cycle of latency.
module gb_fb_writer #(
  parameter int GB_W = 160,
  parameter int GB_H = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  gb_pix,
  input  logic        gb_valid,
  input  logic        gb_hs,
  input  logic        gb_vs,
  output logic        wr_en,
  output logic [14:0] wr_addr,
  output logic [1:0]  wr_data,
  output logic        vsi,
  output logic        frame_done,
  output logic        err_long,
  output logic        err_short
);

  localparam int XW = $clog2(GB_W + 1);
  localparam int YW = $clog2(GB_H + 1);
  localparam logic [XW-1:0] X_MAX     = XW'(GB_W);
  localparam logic [YW-1:0] Y_MAX     = YW'(GB_H);
  localparam logic [YW-1:0] Y_LAST    = YW'(GB_H - 1);
  localparam logic [14:0]   BASE_STEP = 15'(GB_W);

  typedef enum logic [1:0] {WAIT_VS, CAPTURE, DONE} state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [14:0]   line_base;
  logic          hs_prev;
  logic          vs_prev;

  logic          hs_edge;
  logic          vs_edge;
  logic          accept;
  logic [XW-1:0] x_end;

  assign hs_edge = gb_hs & ~hs_prev;
  assign vs_edge = gb_vs & ~vs_prev;
  assign accept  = (state == CAPTURE) && gb_valid && (x < X_MAX) && (y < Y_MAX);
  // Pixel count of the line as it stands once this cycle's pixel (if any) lands.
  assign x_end   = accept ? x + XW'(1) : x;

  // NOTE: every register here is reset, including the write port, so a mid-frame
  // reset leaves the framebuffer interface fully idle rather than holding stale values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_VS;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      hs_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      vsi        <= 1'b0;
      frame_done <= 1'b0;
      err_long   <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; where the pixel and line-end branches
      // both assign x, the later one (line end) wins, giving write-then-advance order.
      hs_prev    <= gb_hs;
      vs_prev    <= gb_vs;
      wr_en      <= 1'b0;
      vsi        <= 1'b0;
      frame_done <= 1'b0;

      if (vs_edge) begin
        state     <= CAPTURE;
        x         <= '0;
        y         <= '0;
        line_base <= '0;
        vsi       <= 1'b1;
      end else begin
        case (state)
          CAPTURE: begin
            if (gb_valid) begin
              if (accept) begin
                wr_en   <= 1'b1;
                wr_addr <= line_base + 15'(x);
                wr_data <= gb_pix;
                x       <= x + XW'(1);
              end else begin
                err_long <= 1'b1;
              end
            end
            if (hs_edge) begin
              x         <= '0;
              y         <= y + YW'(1);
              line_base <= line_base + BASE_STEP;
              if (x_end != '0 && x_end < X_MAX) err_short <= 1'b1;
              if (y == Y_LAST) begin
                frame_done <= 1'b1;
                state      <= DONE;
              end
            end
          end
          DONE: begin
            if (gb_valid) err_long <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
